full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: sout  output  WIDTH  registered sum bits.
REQ-005 Port: cout  output  1  registered carry-out.
REQ-006 Port: a  input  WIDTH  addend.
REQ-007 Port: b  input  WIDTH  addend.
REQ-008 Port: cin  input  1  carry-in, added at the LSB.
REQ-009 Positional port order SHALL be sout, cout, a, b, cin, clk, rst, so existing positional instantiations of the 5 datapath ports stay valid.
REQ-010 Clocking SHALL be one clock domain (clk); reset SHALL be asynchronous and active-high (rst).

Function
REQ-011 The combinational result SHALL be {c, s} = a + b + cin, computed at WIDTH+1 bits with no overflow loss.
REQ-012 For WIDTH = 1, s SHALL equal a XOR b XOR cin, and c SHALL equal (a AND b) OR (a AND cin) OR (b AND cin).
REQ-013 For WIDTH > 1, the result SHALL be a ripple of 1-bit full-adder cells: bit i carry-in is the carry-out of bit i-1, bit 0 carry-in is cin, and c is the carry-out of bit WIDTH-1.
REQ-014 On each rising clk edge with rst low, sout SHALL load s and cout SHALL load c.
REQ-015 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on sout/cout immediately after edge N.
REQ-016 There SHALL be no handshake; a new operation is accepted every cycle with full throughput.
REQ-017 Outputs SHALL change only on a clk edge or on rst assertion; input glitches between edges SHALL NOT propagate to the outputs.
REQ-018 Wrap-around: when a + b + cin reaches or exceeds 2^WIDTH, sout SHALL hold the low WIDTH bits and cout SHALL be 1.
REQ-019 When a and b are all-ones and cin = 1, the result SHALL be sout all-ones and cout = 1.
REQ-020 The block SHALL contain no state other than the sout and cout registers.
REQ-021 X or Z on any input SHALL NOT corrupt the reset value while rst is high.

Reset
REQ-022 While rst is high, sout SHALL be 0 and cout SHALL be 0, independent of clk.
REQ-023 rst assertion mid-operation SHALL clear the outputs immediately, without waiting for a clk edge; any in-flight result SHALL be discarded.
REQ-024 After rst deasserts, the first rising clk edge SHALL load the current inputs per REQ-014.
REQ-025 Where rst and a clk edge coincide, reset SHALL take priority.

Verification
REQ-026 Bench SHALL cover, each as stimulus -> required response:
- WIDTH=1 exhaustive: all 8 combinations of (a, b, cin), 000 through 111, one per cycle -> {cout, sout} = 00, 01, 01, 10, 01, 10, 10, 11, each one cycle after application.
- Reset mid-stream: rst pulsed high between edges while outputs = 11 -> sout=0, cout=0 immediately; outputs stay 0 until the first edge after rst falls.
- Latency and throughput: back-to-back operands on consecutive cycles -> each result appears exactly one edge later, with no bubbles.
- WIDTH=4 wrap-around: a=15, b=0, cin=1 -> sout=0, cout=1; a=15, b=15, cin=1 -> sout=15, cout=1.
- WIDTH=8 random: 1000 random (a, b, cin) -> {cout, sout} matches a + b + cin on every cycle.
- Glitch immunity: toggle a between edges -> outputs change only at clk edges.

Source files
------------

// File: rtl/full_adder.sv
// Registered ripple-carry adder of parameterisable width.
// A chain of 1-bit full-adder cells forms {carry, sum} = a + b + cin at
// WIDTH+1 bits. The result is captured on the rising clock edge, so the
// outputs follow the inputs by exactly one cycle. The asynchronous
// active-high reset clears both output registers at once.
module full_adder #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] sout,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst
);

    // Sum bit of one full-adder cell.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // Carry-out of one full-adder cell (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    logic [WIDTH-1:0] sout_d;
    logic [WIDTH-1:0] sout_q;
    logic             cout_d;
    logic             cout_q;

    assign carry_s[0] = cin;

    // The ripple chain: cell i takes its carry-in from cell i-1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum_s[i]       = fa_sum(a[i], b[i], carry_s[i]);
        assign carry_s[i + 1] = fa_carry(a[i], b[i], carry_s[i]);
    end

    // Next-state values for the output registers.
    always_comb begin
        sout_d = sum_s;
        cout_d = carry_s[WIDTH];
    end

    // Output registers. Reset has priority over a coinciding clock edge,
    // and the inputs are ignored while reset is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sout_q <= '0;
            cout_q <= 1'b0;
        end else begin
            sout_q <= sout_d;
            cout_q <= cout_d;
        end
    end

    assign sout = sout_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 4 and 8.
module tb_full_adder;

    logic clk;
    logic rst;

    logic [0:0] a1, b1;
    logic       c1;
    logic [0:0] s1;
    logic       co1;

    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] s4;
    logic       co4;

    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] s8;
    logic       co8;

    int tests;
    int fails;

    // Reference results: what {cout, sout} must be after the last edge.
    logic [1:0] exp1;
    logic [4:0] exp4;
    logic [8:0] exp8;

    logic [1:0] tbl [8];

    full_adder #(.WIDTH(1)) dut1 (
        .sout(s1), .cout(co1), .a(a1), .b(b1), .cin(c1), .clk(clk), .rst(rst)
    );
    full_adder #(.WIDTH(4)) dut4 (
        .sout(s4), .cout(co4), .a(a4), .b(b4), .cin(c4), .clk(clk), .rst(rst)
    );
    full_adder #(.WIDTH(8)) dut8 (
        .sout(s8), .cout(co8), .a(a8), .b(b8), .cin(c8), .clk(clk), .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: integer sum of the operands present at the edge, cleared by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp1 <= 2'd0;
            exp4 <= 5'd0;
            exp8 <= 9'd0;
        end else begin
            exp1 <= 2'(int'(a1) + int'(b1) + int'(c1));
            exp4 <= 5'(int'(a4) + int'(b4) + int'(c4));
            exp8 <= 9'(int'(a8) + int'(b8) + int'(c8));
        end
    end

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        check("w1_model", {62'd0, co1, s1}, {62'd0, exp1});
        check("w4_model", {59'd0, co4, s4}, {59'd0, exp4});
        check("w8_model", {55'd0, co8, s8}, {55'd0, exp8});
    end

    initial begin
        logic [7:0] hold8;
        logic       holdc8;
        logic [2:0] v;

        tests = 0;
        fails = 0;
        tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b01; tbl[3] = 2'b10;
        tbl[4] = 2'b01; tbl[5] = 2'b10; tbl[6] = 2'b10; tbl[7] = 2'b11;

        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;

        // Reset state, including with X on the inputs while rst is high.
        #2;
        a8 = 8'hxx; c4 = 1'bx;
        @(posedge clk);
        #1;
        check("rst_w1", {62'd0, co1, s1}, 64'd0);
        check("rst_w8_x_in", {55'd0, co8, s8}, 64'd0);
        a8 = 8'd0; c4 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;

        // WIDTH=1 exhaustive, back to back: each result one edge later.
        @(posedge clk);
        #2 {a1, b1, c1} = 3'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            v = 3'(i);
            check($sformatf("w1_vec_%0d%0d%0d", v[2], v[1], v[0]), {62'd0, co1, s1}, {62'd0, tbl[i]});
            #1;
            if (i < 7) {a1, b1, c1} = 3'(i + 1);
        end

        // Reset pulse between edges while outputs read 11.
        #1 rst = 1'b1;
        #1;
        check("midrst_immediate", {62'd0, co1, s1}, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_hold_until_edge", {62'd0, co1, s1}, 64'd0);
        @(posedge clk);
        #1;
        check("midrst_first_edge_loads", {62'd0, co1, s1}, 64'd3);

        // WIDTH=4 wrap-around cases.
        #1 begin a4 = 4'd15; b4 = 4'd0; c4 = 1'b1; end
        @(posedge clk);
        #1;
        check("w4_15_0_1", {59'd0, co4, s4}, {59'd0, 1'b1, 4'd0});
        #1 begin a4 = 4'd15; b4 = 4'd15; c4 = 1'b1; end
        @(posedge clk);
        #1;
        check("w4_15_15_1", {59'd0, co4, s4}, {59'd0, 1'b1, 4'd15});
        #1 begin a4 = 4'd7; b4 = 4'd8; c4 = 1'b0; end
        @(posedge clk);
        #1;
        check("w4_7_8_0", {59'd0, co4, s4}, {59'd0, 1'b0, 4'd15});
        #1 begin a8 = 8'd200; b8 = 8'd100; c8 = 1'b1; end
        @(posedge clk);
        #1;
        check("w8_200_100_1", {55'd0, co8, s8}, {55'd0, 9'd301});

        // Glitch immunity: toggle a between edges, outputs must hold.
        hold8 = s8;
        holdc8 = co8;
        for (int k = 0; k < 5; k++) begin
            #1 a8 = ~a8;
            check("glitch_sout", {56'd0, s8}, {56'd0, hold8});
            check("glitch_cout", {63'd0, co8}, {63'd0, holdc8});
        end
        a8 = 8'd1; b8 = 8'd2; c8 = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_then_edge", {55'd0, co8, s8}, 64'd3);

        // WIDTH=8 random operands, one per cycle; compare process checks each.
        for (int r = 0; r < 1000; r++) begin
            #1;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
